pll_reset_sequencer: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_reset_sequencer.sv | 132 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset/lock supervisor.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABILIZE,
      RUN,
      FAIL
   } seq_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Bits needed to hold any value in 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single level-type status bit.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies lock with retries,
// and holds the core reset until lock has been stable on the reference clock.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 742500,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES         = 3
) (
   input  logic                               refclk,
   input  logic                               rst,
   input  logic                               pll_locked,
   input  logic                               retry,
   output logic                               pll_rst,
   output logic                               sys_rst,
   output logic                               lock_lost,
   output logic                               fail,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

   localparam int RW = $clog2(MAX_RETRIES + 1);
   localparam int CW = cnt_width(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES));

   // The shared counter runs down to zero, so each phase loads its length minus one.
   localparam logic [CW-1:0] PULSE_LOAD   = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LOAD  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

   seq_state_t      state, next_state;
   logic [CW-1:0]   cnt, next_cnt;
   logic [RW-1:0]   next_retry, retry_inc;
   logic            next_pll_rst, next_sys_rst, next_fail, next_lock_lost;
   logic            lk;

   sync_2ff u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lk)
   );

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state       <= RESET_PLL;
         cnt         <= PULSE_LOAD;
         retry_count <= '0;
         pll_rst     <= 1'b1;
         sys_rst     <= 1'b1;
         fail        <= 1'b0;
         lock_lost   <= 1'b0;
      end else begin
         state       <= next_state;
         cnt         <= next_cnt;
         retry_count <= next_retry;
         pll_rst     <= next_pll_rst;
         sys_rst     <= next_sys_rst;
         fail        <= next_fail;
         lock_lost   <= next_lock_lost;
      end
   end

   // Outputs are decoded from the next state so they move on the committing edge.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      next_retry = retry_count;
      retry_inc  = (retry_count == RETRY_LIMIT) ? retry_count : retry_count + 1'b1;

      case (state)
         RESET_PLL: begin
            if (cnt == '0) begin
               next_state = WAIT_LOCK;
               next_cnt   = TIMEOUT_LOAD;
            end else begin
               next_cnt = cnt - 1'b1;
            end
         end
         WAIT_LOCK: begin
            if (lk) begin
               next_state = STABILIZE;
               next_cnt   = STABLE_LOAD;
            end else if (cnt == '0) begin
               next_retry = retry_inc;
               if (retry_inc == RETRY_LIMIT) begin
                  next_state = FAIL;
               end else begin
                  next_state = RESET_PLL;
                  next_cnt   = PULSE_LOAD;
               end
            end else begin
               next_cnt = cnt - 1'b1;
            end
         end
         STABILIZE: begin
            if (!lk) begin
               next_state = WAIT_LOCK;
               next_cnt   = TIMEOUT_LOAD;
            end else if (cnt == '0) begin
               next_state = RUN;
               next_retry = '0;
            end else begin
               next_cnt = cnt - 1'b1;
            end
         end
         RUN: begin
            if (!lk) begin
               next_state = RESET_PLL;
               next_cnt   = PULSE_LOAD;
            end
         end
         FAIL: begin
            if (retry) begin
               next_state = RESET_PLL;
               next_cnt   = PULSE_LOAD;
               next_retry = '0;
            end
         end
         default: begin
            next_state = RESET_PLL;
            next_cnt   = PULSE_LOAD;
         end
      endcase

      next_pll_rst   = (next_state == RESET_PLL) || (next_state == FAIL);
      next_sys_rst   = (next_state != RUN);
      next_fail      = (next_state == FAIL);
      next_lock_lost = (state == RUN) && (next_state == RESET_PLL);
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short pulse/timeout/stable lengths.
module tb_pll_reset_sequencer;

   logic       refclk;
   logic       rst;
   logic       pll_locked;
   logic       retry;
   logic       pll_rst;
   logic       sys_rst;
   logic       lock_lost;
   logic       fail;
   logic [1:0] retry_count;

   int total_checks = 0;
   int bad_checks   = 0;
   int n;
   int ll;

   pll_reset_sequencer #(
      .RST_PULSE_CYCLES    (4),
      .LOCK_TIMEOUT_CYCLES (100),
      .LOCK_STABLE_CYCLES  (16),
      .MAX_RETRIES         (2)
   ) dut (
      .refclk      (refclk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .retry       (retry),
      .pll_rst     (pll_rst),
      .sys_rst     (sys_rst),
      .lock_lost   (lock_lost),
      .fail        (fail),
      .retry_count (retry_count)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   task automatic checkOutput(input string tag, input int got, input int exp);
      total_checks++;
      if (got != exp) begin
         bad_checks++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance to just after the next active edge.
   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic applyStimulus(input logic locked_val, input logic retry_val);
      pll_locked = locked_val;
      retry      = retry_val;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic count_pll_rst_high(output int cnt_o);
      cnt_o = 0;
      while (pll_rst === 1'b1 && cnt_o < 1000) begin
         tick();
         cnt_o++;
      end
   endtask

   task automatic count_pll_rst_low(output int cnt_o);
      cnt_o = 0;
      while (pll_rst === 1'b0 && cnt_o < 1000) begin
         tick();
         cnt_o++;
      end
   endtask

   task automatic count_sys_rst_high(output int cnt_o);
      cnt_o = 0;
      while (sys_rst === 1'b1 && cnt_o < 1000) begin
         tick();
         cnt_o++;
      end
   endtask

   task automatic count_sys_rst_low(output int cnt_o);
      cnt_o = 0;
      while (sys_rst === 1'b0 && cnt_o < 1000) begin
         tick();
         cnt_o++;
      end
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0);
      tick();
      tick();
      checkOutput("reset_pll_rst", pll_rst, 1);
      checkOutput("reset_sys_rst", sys_rst, 1);
      checkOutput("reset_lock_lost", lock_lost, 0);
      checkOutput("reset_fail", fail, 0);
      checkOutput("reset_retry_count", retry_count, 0);

      // Clean lock
      rst = 1'b0;
      count_pll_rst_high(n);
      checkOutput("s1_pulse_len", n, 4);
      repeat (10) tick();
      applyStimulus(1'b1, 1'b0);
      count_sys_rst_high(n);
      checkOutput("s1_lock_to_run", n, 19);
      checkOutput("s1_retry_count", retry_count, 0);
      checkOutput("s1_pll_rst_run", pll_rst, 0);

      // Single timeout, then lock on the second attempt
      apply_reset();
      count_pll_rst_high(n);
      checkOutput("s2_pulse1_len", n, 4);
      count_pll_rst_low(n);
      checkOutput("s2_timeout_len", n, 100);
      checkOutput("s2_retry_after_to", retry_count, 1);
      count_pll_rst_high(n);
      checkOutput("s2_pulse2_len", n, 4);
      checkOutput("s2_retry_attempt2", retry_count, 1);
      applyStimulus(1'b1, 1'b0);
      count_sys_rst_high(n);
      checkOutput("s2_lock_to_run", n, 19);
      checkOutput("s2_retry_run", retry_count, 0);

      // Exhausted retries, then recovery via retry
      apply_reset();
      count_pll_rst_high(n);
      checkOutput("s3_pulse1_len", n, 4);
      count_pll_rst_low(n);
      checkOutput("s3_timeout1_len", n, 100);
      count_pll_rst_high(n);
      checkOutput("s3_pulse2_len", n, 4);
      count_pll_rst_low(n);
      checkOutput("s3_timeout2_len", n, 100);
      checkOutput("s3_fail", fail, 1);
      checkOutput("s3_fail_pll_rst", pll_rst, 1);
      checkOutput("s3_fail_retry_count", retry_count, 2);
      repeat (5) tick();
      checkOutput("s3_fail_held", fail, 1);
      checkOutput("s3_fail_sys_rst", sys_rst, 1);
      applyStimulus(1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0);
      checkOutput("s3_retry_fail", fail, 0);
      checkOutput("s3_retry_count_clr", retry_count, 0);
      count_pll_rst_high(n);
      checkOutput("s3_restart_pulse_len", n, 4);
      applyStimulus(1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0);
      checkOutput("s3_retry_ignored_pll_rst", pll_rst, 0);
      checkOutput("s3_retry_ignored_fail", fail, 0);

      // Glitchy lock during qualification
      applyStimulus(1'b1, 1'b0);
      repeat (13) tick();
      checkOutput("s4_in_stabilize_sys_rst", sys_rst, 1);
      applyStimulus(1'b0, 1'b0);
      repeat (3) tick();
      checkOutput("s4_glitch_sys_rst", sys_rst, 1);
      checkOutput("s4_glitch_pll_rst", pll_rst, 0);
      applyStimulus(1'b1, 1'b0);
      count_sys_rst_high(n);
      checkOutput("s4_requal_len", n, 19);

      // Lock loss while running
      applyStimulus(1'b0, 1'b0);
      count_sys_rst_low(n);
      checkOutput("s5_drop_to_sys_rst", n, 3);
      checkOutput("s5_lock_lost", lock_lost, 1);
      checkOutput("s5_pll_rst_rise", pll_rst, 1);
      checkOutput("s5_retry_count", retry_count, 0);
      n  = 0;
      ll = 0;
      while (pll_rst === 1'b1 && n < 1000) begin
         tick();
         n++;
         if (lock_lost === 1'b1) ll++;
      end
      checkOutput("s5_pulse_len", n, 4);
      checkOutput("s5_lock_lost_extra", ll, 0);

      // Asynchronous reset while qualifying lock on a retried attempt
      count_pll_rst_low(n);
      checkOutput("s6_timeout_len", n, 100);
      count_pll_rst_high(n);
      checkOutput("s6_pulse_len", n, 4);
      applyStimulus(1'b1, 1'b0);
      repeat (8) tick();
      checkOutput("s6_pre_retry_count", retry_count, 1);
      checkOutput("s6_pre_pll_rst", pll_rst, 0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("s6_async_pll_rst", pll_rst, 1);
      checkOutput("s6_async_sys_rst", sys_rst, 1);
      checkOutput("s6_async_retry_count", retry_count, 0);
      checkOutput("s6_async_fail", fail, 0);
      checkOutput("s6_async_lock_lost", lock_lost, 0);

      // Lock arriving on the exact timeout cycle wins
      applyStimulus(1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      count_pll_rst_high(n);
      checkOutput("s6_tie_pulse_len", n, 4);
      repeat (97) tick();
      applyStimulus(1'b1, 1'b0);
      repeat (3) tick();
      checkOutput("s6_tie_retry_count", retry_count, 0);
      checkOutput("s6_tie_pll_rst", pll_rst, 0);
      checkOutput("s6_tie_fail", fail, 0);
      count_sys_rst_high(n);
      checkOutput("s6_tie_qual_len", n, 16);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
